// File: rtl/ram_dma_pkg.sv
// ram_dma_pkg: shared FSM state encodings and command mode constants for
// the ram_dma block.
package ram_dma_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  localparam logic MODE_FILL = 1'b0;
  localparam logic MODE_COPY = 1'b1;

endpackage

// File: rtl/ram_dma.sv
// ram_dma: fill/copy engine driving a single-port RAM.
//   clock, reset        : single clock, synchronous active-high reset
//   start, mode         : command strobe (accepted only in IDLE), 0=fill 1=copy
//   src, dst, len       : copy source base, destination base, word count
//   fill_value          : data written by a fill command
//   busy, done          : command executing / one-cycle completion pulse
//   mem_address/mem_data/mem_wren : RAM port (address and enable registered)
//   mem_q               : RAM read data, valid one cycle after a read address
module ram_dma
  import ram_dma_pkg::*;
#(
  parameter int widthad_a = 15,
  parameter int width_a   = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 mode,
  input  logic [widthad_a-1:0] src,
  input  logic [widthad_a-1:0] dst,
  input  logic [widthad_a:0]   len,
  input  logic [width_a-1:0]   fill_value,
  output logic                 busy,
  output logic                 done,
  output logic [widthad_a-1:0] mem_address,
  output logic [width_a-1:0]   mem_data,
  output logic                 mem_wren,
  input  logic [width_a-1:0]   mem_q
);

  state_t               state;
  logic                 mode_r;
  logic [widthad_a-1:0] src_r, dst_r;
  logic [widthad_a:0]   len_r, idx;
  logic [width_a-1:0]   fill_r;
  logic                 wren_r;

  logic [widthad_a:0]   idx_nxt;
  logic                 last;

  assign idx_nxt = idx + 1'b1;
  assign last    = (idx_nxt == len_r);

  // The write of the cycle in which reset is high must not land in the RAM,
  // so the registered enable is killed combinationally by reset.
  assign mem_wren = wren_r & ~reset;

  // Copy writes forward the word read in the preceding RD cycle.
  assign mem_data = (state == S_WR && mode_r == MODE_COPY) ? mem_q : fill_r;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      wren_r      <= 1'b0;
      mem_address <= '0;
      fill_r      <= '0;
      mode_r      <= MODE_FILL;
      src_r       <= '0;
      dst_r       <= '0;
      len_r       <= '0;
      idx         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_r <= mode;
            src_r  <= src;
            dst_r  <= dst;
            len_r  <= len;
            fill_r <= fill_value;
            idx    <= '0;
            if (len == '0) begin
              state <= S_FIN;
              done  <= 1'b1;
            end else if (mode == MODE_COPY) begin
              state       <= S_RD;
              busy        <= 1'b1;
              mem_address <= src;
              wren_r      <= 1'b0;
            end else begin
              state       <= S_WR;
              busy        <= 1'b1;
              mem_address <= dst;
              wren_r      <= 1'b1;
            end
          end
        end
        S_RD: begin
          state       <= S_WR;
          mem_address <= dst_r + idx[widthad_a-1:0];
          wren_r      <= 1'b1;
        end
        S_WR: begin
          idx <= idx_nxt;
          if (last) begin
            state  <= S_FIN;
            busy   <= 1'b0;
            done   <= 1'b1;
            wren_r <= 1'b0;
          end else if (mode_r == MODE_COPY) begin
            state       <= S_RD;
            mem_address <= src_r + idx_nxt[widthad_a-1:0];
            wren_r      <= 1'b0;
          end else begin
            mem_address <= dst_r + idx_nxt[widthad_a-1:0];
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: begin
          state  <= S_IDLE;
          busy   <= 1'b0;
          wren_r <= 1'b0;
        end
      endcase
    end
  end

endmodule
